// File: rtl/keypad_pkg.sv
// Shared constants, scan FSM state type and one-hot helper for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic {
    SCAN,
    EVAL
  } scan_state_t;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-code stream from the scanner (master) to the display path (slave).
interface keypad_scanner_if;
  logic [15:0] scan_data;
  logic        valid;

  modport master (output scan_data, output valid);
  modport slave  (input  scan_data, input  valid);
endinterface

// File: rtl/keypad_debounce.sv
// Sweep-level debouncer: accepts a key vector after DEB_SWEEPS identical sweeps.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_SWEEPS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sweep_vec,
  input  logic        sweep_done,
  output logic        accept,
  output logic        release_evt,
  output logic [15:0] data
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_SWEEPS);

  logic [15:0] prev_vec_reg, prev_vec_next;
  logic [15:0] deb_state_reg, deb_state_next;
  logic [3:0]  stable_cnt_reg, stable_cnt_next;
  logic        reached;

  always_comb begin
    prev_vec_next   = prev_vec_reg;
    stable_cnt_next = stable_cnt_reg;
    deb_state_next  = deb_state_reg;
    reached         = 1'b0;
    accept          = 1'b0;
    release_evt     = 1'b0;
    if (sweep_done) begin
      if (sweep_vec == prev_vec_reg) begin
        if (stable_cnt_reg < DEB_MAX)
          stable_cnt_next = stable_cnt_reg + 4'd1;
        reached = (stable_cnt_reg == DEB_MAX - 4'd1);
      end else begin
        prev_vec_next   = sweep_vec;
        stable_cnt_next = 4'd1;
        reached         = (DEB_MAX == 4'd1);
      end
      // Multi-key vectors fall through both branches and are silently rejected.
      if (reached && (prev_vec_next != deb_state_reg)) begin
        if (is_onehot(prev_vec_next)) begin
          accept         = 1'b1;
          deb_state_next = prev_vec_next;
        end else if (prev_vec_next == 16'h0000) begin
          release_evt    = 1'b1;
          deb_state_next = 16'h0000;
        end
      end
    end
  end

  assign data = prev_vec_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_vec_reg   <= '0;
      deb_state_reg  <= '0;
      stable_cnt_reg <= '0;
    end else begin
      prev_vec_reg   <= prev_vec_next;
      deb_state_reg  <= deb_state_next;
      stable_cnt_reg <= stable_cnt_next;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad matrix and emits a debounced one-hot key code.
// Define KEYPAD_RELEASE_EVT_EN to also report accepted releases as scan_data = 0 with valid.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CNT   = 1000,
  parameter int DEB_SWEEPS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  keypad_scanner_if.master    scan_if
);

  localparam int CNT_W = $clog2(SCAN_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT - 1);
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit RELEASE_EVT = 1'b1;
`else
  localparam bit RELEASE_EVT = 1'b0;
`endif

  scan_state_t         state_reg;
  logic [1:0]          col_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [15:0]         sweep_vec_reg;
  logic [15:0]         capture_vec;
  logic [NUM_COLS-1:0] col_out_reg;
  logic [NUM_ROWS-1:0] row_meta_reg, row_sync_reg;
  logic [15:0]         scan_data_reg;
  logic                valid_reg;
  logic                sweep_done;
  logic                accept_w, release_w;
  logic [15:0]         data_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Only the column currently driven takes the freshly sampled rows.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
      assign capture_vec[NUM_COLS*gi+gj] = (col_reg == 2'(gj)) ? ~row_sync_reg[gi]
                                                               : sweep_vec_reg[NUM_COLS*gi+gj];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= SCAN;
      col_reg       <= '0;
      cnt_reg       <= '0;
      sweep_vec_reg <= '0;
      col_out_reg   <= COL_IDLE;
    end else begin
      case (state_reg)
        SCAN: begin
          col_out_reg <= ~(4'b0001 << col_reg);
          if (cnt_reg == CNT_LAST) begin
            sweep_vec_reg <= capture_vec;
            cnt_reg       <= '0;
            if (col_reg == 2'd3) begin
              state_reg <= EVAL;
              col_reg   <= '0;
            end else begin
              col_reg <= col_reg + 2'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        EVAL: begin
          col_out_reg <= COL_IDLE;
          state_reg   <= SCAN;
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign sweep_done = (state_reg == EVAL);

  keypad_debounce #(
    .DEB_SWEEPS (DEB_SWEEPS)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .sweep_vec   (sweep_vec_reg),
    .sweep_done  (sweep_done),
    .accept      (accept_w),
    .release_evt (release_w),
    .data        (data_w)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_data_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= accept_w | (RELEASE_EVT & release_w);
      if (accept_w)
        scan_data_reg <= data_w;
      else if (RELEASE_EVT && release_w)
        scan_data_reg <= '0;
    end
  end

  assign col_out           = col_out_reg;
  assign scan_if.scan_data = scan_data_reg;
  assign scan_if.valid     = valid_reg;

endmodule
